// File: rtl/mixer_mc.sv
// ============================================================================
//  Module      : mixer_mc
//  Description : Time-multiplexed multichannel stereo mixer with soft mute
//                and first-order sigma-delta DAC bitstreams.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mixer_mc #(
    parameter int NCH = 6,
    parameter int SW  = 8,
    parameter int VW  = 4
) (
    input  logic              clk28,
    input  logic              rst_n,
    input  logic [NCH*SW-1:0] ch_sample,
    input  logic [NCH*VW-1:0] ch_vol,
    input  logic [NCH*2-1:0]  ch_pan,
    input  logic              mute,
    output logic              sample_tick,
    output logic              muted,
    output logic              dac_l,
    output logic              dac_r
);

    localparam int MW = SW + VW + $clog2(NCH);
    localparam int PW = SW + VW;
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int AW = $clog2(MW + 1);

    typedef enum logic [0:0] {
        S_ACCUM = 1'b0,
        S_LATCH = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   w_idx_nxt;
    logic            w_accum;
    logic            w_latch;

    logic [SW-1:0]   w_smp;
    logic [VW-1:0]   w_vol;
    logic [1:0]      w_pan;
    logic [PW-1:0]   w_prod;

    logic [MW-1:0]   r_acc_l;
    logic [MW-1:0]   r_acc_r;
    logic [MW-1:0]   r_hold_l;
    logic [MW-1:0]   r_hold_r;
    logic [MW:0]     r_cnt_l;
    logic [MW:0]     r_cnt_r;
    logic [AW-1:0]   r_att;
    logic            r_tick;
    logic            r_muted;

    // Sweep sequencer: slots 0..NCH-1 accumulate, one extra cycle latches.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_ACCUM;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_accum     = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            S_ACCUM: begin
                w_accum = 1'b1;
                if (r_idx == IW'(NCH - 1)) begin
                    w_state_nxt = S_LATCH;
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt   = r_idx + 1'b1;
                end
            end
            S_LATCH: begin
                w_latch     = 1'b1;
                w_state_nxt = S_ACCUM;
                w_idx_nxt   = '0;
            end
            default: begin
                w_state_nxt = S_ACCUM;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Only the channel owning the current slot is looked at.
    always_comb begin
        w_smp = '0;
        w_vol = '0;
        w_pan = '0;
        for (int k = 0; k < NCH; k++) begin
            if (r_idx == IW'(k)) begin
                w_smp = ch_sample[k*SW +: SW];
                w_vol = ch_vol[k*VW +: VW];
                w_pan = ch_pan[k*2 +: 2];
            end
        end
    end

    assign w_prod = PW'(w_smp) * PW'(w_vol);

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_l  <= '0;
            r_acc_r  <= '0;
            r_hold_l <= '0;
            r_hold_r <= '0;
            r_att    <= '0;
            r_tick   <= 1'b0;
            r_muted  <= 1'b0;
        end else begin
            r_tick  <= w_latch;
            r_muted <= (r_att == AW'(MW));
            if (w_accum) begin
                if (w_pan[0]) begin
                    r_acc_l <= r_acc_l + MW'(w_prod);
                end
                if (w_pan[1]) begin
                    r_acc_r <= r_acc_r + MW'(w_prod);
                end
            end else if (w_latch) begin
                // Hold samples the old attenuation; the fade step lands afterwards.
                r_hold_l <= r_acc_l >> r_att;
                r_hold_r <= r_acc_r >> r_att;
                r_acc_l  <= '0;
                r_acc_r  <= '0;
                if (mute) begin
                    if (r_att != AW'(MW)) begin
                        r_att <= r_att + 1'b1;
                    end
                end else if (r_att != '0) begin
                    r_att <= r_att - 1'b1;
                end
            end
        end
    end

    // First-order sigma-delta: the carry out of the MW-bit accumulator is the bitstream.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_l <= '0;
            r_cnt_r <= '0;
        end else begin
            r_cnt_l <= {1'b0, r_cnt_l[MW-1:0]} + {1'b0, r_hold_l};
            r_cnt_r <= {1'b0, r_cnt_r[MW-1:0]} + {1'b0, r_hold_r};
        end
    end

    assign dac_l       = r_cnt_l[MW];
    assign dac_r       = r_cnt_r[MW];
    assign sample_tick = r_tick;
    assign muted       = r_muted;

endmodule

`default_nettype wire

// File: doc/mixer_mc.md
MIXER_MC -- requirements
Module: mixer_mc

Interface
REQ-001 Parameter NCH, default 6: number of mixed channels, 1..16.
REQ-002 Parameter SW, default 8: unsigned sample width per channel.
REQ-003 Parameter VW, default 4: unsigned per-channel volume width.
REQ-004 Derived MW = SW + VW + clog2(NCH): mix sum width; no overflow possible at full scale.
REQ-005 clk28  input  1  system clock; all logic on its rising edge.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 ch_sample  input  NCH*SW  packed channel samples; channel k at bits [k*SW +: SW].
REQ-008 ch_vol  input  NCH*VW  packed channel volumes; 0 = silent, all-ones = unity weight.
REQ-009 ch_pan  input  NCH*2  per channel {route_r, route_l}; bit set routes the channel to that side.
REQ-010 mute  input  1  level request for a soft mute (fade out); deassertion fades back in.
REQ-011 sample_tick  output  1  one-clock pulse when new mix values are latched.
REQ-012 muted  output  1  high while attenuation is at maximum (MW).
REQ-013 dac_l  output  1  left first-order sigma-delta bitstream.
REQ-014 dac_r  output  1  right first-order sigma-delta bitstream.

Function
REQ-015 Time-multiplexed sweep: slot counter idx steps 0..NCH-1 (ACCUM), then one LATCH cycle, then back to 0; sweep period NCH+1 clocks, free-running.
REQ-016 In ACCUM slot k: product p = ch_sample[k] * ch_vol[k] (SW+VW bits, unsigned); acc_l += p if route_l[k]; acc_r += p if route_r[k]; inputs sampled only in their own slot.
REQ-017 Accumulators acc_l/acc_r are MW bits; they clear at LATCH so slot 0 starts from zero.
REQ-018 In LATCH: hold_l <= acc_l >> att; hold_r <= acc_r >> att; sample_tick = 1 for exactly this cycle.
REQ-019 Attenuation att: 0..MW, updated in LATCH after hold registers load; mute=1 -> att+1 saturating at MW; mute=0 -> att-1 saturating at 0; one step per sweep.
REQ-020 muted = (att == MW), registered; changes on the clock following the LATCH that reaches/leaves MW.
REQ-021 Sigma-delta per side, every clock: cnt (MW+1 bits) <= cnt[MW-1:0] + hold; dac = cnt[MW]; average duty = hold / 2^MW.
REQ-022 hold = 0 -> dac constantly 0 after first clock; no idle tones from accumulator residue other than the carried remainder.
REQ-023 Mid-sweep input changes affect only slots not yet visited in the current sweep; no glitch in hold values between LATCH cycles.
REQ-024 Channel with both pan bits set contributes to both sides equally; both clear contributes nothing.
REQ-025 NCH=1: sweep is 2 clocks (slot 0, LATCH); all rules still apply.

Reset
REQ-026 While rst_n=0: idx=0 (ACCUM), acc_l=acc_r=0, hold_l=hold_r=0, cnt_l=cnt_r=0, att=0, sample_tick=0, muted=0, dac_l=dac_r=0.
REQ-027 Reset assertion mid-sweep aborts the sweep immediately; after release the first sample_tick occurs on clock NCH+1.
REQ-028 mute held high through reset release: fade starts from att=0, no jump to muted.

Verification (NCH=6, SW=8, VW=4, MW=15)
REQ-029 ch0 sample=255 vol=15 pan=L, others vol=0 -> hold_l=3825, hold_r=0; dac_l high exactly 3825 of any aligned 32768 clocks after steady state; dac_r always 0.
REQ-030 All channels 255/15 pan=LR -> hold_l=hold_r=22950; no overflow; sample_tick every 7 clocks.
REQ-031 Same stimulus, mute=1 -> hold halves each sweep (11475, 5737, ...); muted=1 after 15 LATCHes; mute=0 -> restores 22950 after 15 LATCHes.
REQ-032 Change ch2 sample 0->100 (vol 15, pan L) in slot 4 -> current latch excludes it, next latch adds 1500.
REQ-033 rst_n low at slot 3 with nonzero acc -> all outputs 0 during reset; first sample_tick exactly 7 clocks after release.
REQ-034 ch_pan=0 all channels with nonzero samples -> hold_l=hold_r=0, dac_l=dac_r=0 continuously.
